// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock-enable / divider generator
// Define CLKDIV_SYNC_EN to add sync_in, which phase-aligns every channel.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module clk_div_multi #(
    parameter int WIDTH    = `DATA_WIDTH,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] div_ratio,
    input  logic [CHANNELS-1:0]       ratio_load,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       chan_en,
`ifdef CLKDIV_SYNC_EN
    input  logic                      sync_in,
`endif
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       ratio_ack
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] active_q;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] cnt_q;
        logic             pending_q;
        logic             clk_out_q;
        logic             tick_q;
        logic             ack_q;
        logic [WIDTH-1:0] ratio_in;
        logic             load;
        logic             running;
        logic             wrap;

        assign ratio_in = div_ratio[g*WIDTH +: WIDTH];
        assign load     = ratio_load[g];
        assign running  = chan_en[g] && (active_q != '0);
        assign wrap     = running && (cnt_q == active_q - WIDTH'(1));

        always_ff @(posedge clk) begin
            if (reset) begin
                active_q  <= '0;
                shadow_q  <= '0;
                cnt_q     <= '0;
                pending_q <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
                ack_q     <= 1'b0;
            end
`ifdef CLKDIV_SYNC_EN
            else if (sync_in) begin
                // Alignment restarts the phase; a waiting ratio is promoted now,
                // while a load in the same cycle is kept for the next boundary.
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
                ack_q     <= pending_q;
                if (pending_q) begin
                    active_q <= shadow_q;
                end
                if (load) begin
                    shadow_q  <= ratio_in;
                    pending_q <= 1'b1;
                end else begin
                    pending_q <= 1'b0;
                end
            end
`endif
            else if (running) begin
                if (wrap) begin
                    cnt_q     <= '0;
                    tick_q    <= 1'b1;
                    clk_out_q <= mode[g] ? ~clk_out_q : 1'b1;
                    if (load) begin
                        // A load landing on the boundary skips the shadow stage.
                        active_q  <= ratio_in;
                        shadow_q  <= ratio_in;
                        pending_q <= 1'b0;
                        ack_q     <= 1'b1;
                    end else if (pending_q) begin
                        active_q  <= shadow_q;
                        pending_q <= 1'b0;
                        ack_q     <= 1'b1;
                    end else begin
                        ack_q     <= 1'b0;
                    end
                end else begin
                    cnt_q     <= cnt_q + WIDTH'(1);
                    tick_q    <= 1'b0;
                    clk_out_q <= mode[g] & clk_out_q;
                    ack_q     <= 1'b0;
                    if (load) begin
                        shadow_q  <= ratio_in;
                        pending_q <= 1'b1;
                    end
                end
            end else begin
                cnt_q     <= '0;
                tick_q    <= 1'b0;
                clk_out_q <= 1'b0;
                if (load) begin
                    shadow_q  <= ratio_in;
                    pending_q <= 1'b1;
                    ack_q     <= 1'b0;
                end else if (pending_q) begin
                    active_q  <= shadow_q;
                    pending_q <= 1'b0;
                    ack_q     <= 1'b1;
                end else begin
                    ack_q     <= 1'b0;
                end
            end
        end

        assign clk_out[g]   = clk_out_q;
        assign tick[g]      = tick_q;
        assign ratio_ack[g] = ack_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
// Directed table, corner-case sequences and random stimulus against a reference model.
module tb_clk_div_multi;
    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk;
    logic            rst;
    logic [CH*W-1:0] div_ratio;
    logic [CH-1:0]   ratio_load;
    logic [CH-1:0]   mode;
    logic [CH-1:0]   chan_en;
    logic            sync_in;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   ratio_ack;

    int vectors     = 0;
    int miscompares = 0;

    clk_div_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (rst),
        .div_ratio (div_ratio),
        .ratio_load(ratio_load),
        .mode      (mode),
        .chan_en   (chan_en),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .ratio_ack (ratio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase is elapsed cycles since the current ratio took
    // effect; a boundary is reached whenever elapsed+1 is a multiple of R.
    int m_active [CH];
    int m_shadow [CH];
    bit m_pending[CH];
    int m_elapsed[CH];
    bit m_out    [CH];
    bit m_tick   [CH];
    bit m_ack    [CH];

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            int r_in;
            r_in = int'(div_ratio[c*W +: W]);
            m_ack[c] = 0;
            if (rst) begin
                m_active[c] = 0; m_shadow[c] = 0; m_pending[c] = 0;
                m_elapsed[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            end else if (sync_in === 1'b1) begin
                m_elapsed[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                if (m_pending[c]) begin
                    m_active[c] = m_shadow[c];
                    m_ack[c] = 1;
                end
                m_pending[c] = ratio_load[c];
                if (ratio_load[c]) m_shadow[c] = r_in;
            end else if (chan_en[c] && m_active[c] != 0) begin
                if ((m_elapsed[c] + 1) % m_active[c] == 0) begin
                    m_tick[c] = 1;
                    m_out[c]  = mode[c] ? !m_out[c] : 1'b1;
                    if (ratio_load[c]) begin
                        m_active[c] = r_in; m_shadow[c] = r_in;
                        m_pending[c] = 0; m_ack[c] = 1; m_elapsed[c] = 0;
                    end else if (m_pending[c]) begin
                        m_active[c] = m_shadow[c];
                        m_pending[c] = 0; m_ack[c] = 1; m_elapsed[c] = 0;
                    end else begin
                        m_elapsed[c]++;
                    end
                end else begin
                    m_tick[c] = 0;
                    if (!mode[c]) m_out[c] = 0;
                    m_elapsed[c]++;
                    if (ratio_load[c]) begin
                        m_shadow[c] = r_in; m_pending[c] = 1;
                    end
                end
            end else begin
                m_elapsed[c] = 0; m_tick[c] = 0; m_out[c] = 0;
                if (ratio_load[c]) begin
                    m_shadow[c] = r_in; m_pending[c] = 1;
                end else if (m_pending[c]) begin
                    m_active[c] = m_shadow[c]; m_pending[c] = 0; m_ack[c] = 1;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [3*CH-1:0] expv;
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < CH; c++) begin
            expv[2*CH + c] = m_out[c];
            expv[CH + c]   = m_tick[c];
            expv[c]        = m_ack[c];
        end
        check("model {clk_out,tick,ratio_ack}", 32'({clk_out, tick, ratio_ack}), 32'(expv));
    endtask

    task automatic wait_tick(input int ch, input int max_cyc, output int n, output int acks);
        n = 0;
        acks = 0;
        do begin
            cycle();
            n++;
            if (ratio_ack[ch]) acks++;
        end while (!tick[ch] && n < max_cyc);
        check($sformatf("tick_seen ch%0d", ch), 32'(tick[ch]), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1; ratio_load = '0; chan_en = '0; mode = '0; sync_in = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [W-1:0]  r0;
        logic [CH-1:0] ld, md, en, e_out, e_tick, e_ack;
    } vec_t;

    vec_t tbl[25];

    initial begin
        int n, acks, hi, lo, cnt;
        rst = 1'b1; div_ratio = '0; ratio_load = '0; mode = '0; chan_en = '0; sync_in = 1'b0;

        //           rst  r0  ld md en  out tick ack
        tbl[0]  = '{1'b1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 4, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{1'b0, 4, 0, 0, 1, 0, 0, 1};
        tbl[3]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1'b0, 4, 0, 0, 1, 1, 1, 0};
        tbl[7]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[9]  = '{1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{1'b0, 1, 1, 0, 1, 1, 1, 1};
        tbl[11] = '{1'b0, 1, 0, 0, 1, 1, 1, 0};
        tbl[12] = '{1'b0, 1, 0, 0, 1, 1, 1, 0};
        tbl[13] = '{1'b0, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1'b0, 1, 0, 0, 1, 1, 1, 0};
        tbl[15] = '{1'b0, 0, 1, 0, 1, 1, 1, 1};
        tbl[16] = '{1'b0, 0, 0, 0, 1, 0, 0, 0};
        tbl[17] = '{1'b0, 0, 0, 0, 1, 0, 0, 0};
        tbl[18] = '{1'b0, 2, 1, 1, 1, 0, 0, 0};
        tbl[19] = '{1'b0, 2, 0, 1, 1, 0, 0, 1};
        tbl[20] = '{1'b0, 2, 0, 1, 1, 0, 0, 0};
        tbl[21] = '{1'b0, 2, 0, 1, 1, 1, 1, 0};
        tbl[22] = '{1'b0, 2, 0, 1, 1, 1, 0, 0};
        tbl[23] = '{1'b0, 2, 0, 1, 1, 0, 1, 0};
        tbl[24] = '{1'b0, 2, 0, 0, 1, 0, 0, 0};

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst;
            div_ratio = '0;
            div_ratio[W-1:0] = tbl[i].r0;
            ratio_load = tbl[i].ld;
            mode = tbl[i].md;
            chan_en = tbl[i].en;
            cycle();
            check($sformatf("table row %0d", i), 32'({clk_out, tick, ratio_ack}),
                  32'({tbl[i].e_out, tbl[i].e_tick, tbl[i].e_ack}));
        end

        // Two loads inside one period of 5: the later one wins, one ack.
        apply_reset();
        div_ratio[0 +: W] = 8'd5; ratio_load[0] = 1'b1; chan_en[0] = 1'b1;
        cycle();
        ratio_load = '0;
        wait_tick(0, 20, n, acks);
        div_ratio[0 +: W] = 8'd2; ratio_load[0] = 1'b1;
        cycle();
        ratio_load = '0;
        cycle();
        div_ratio[0 +: W] = 8'd7; ratio_load[0] = 1'b1;
        cycle();
        ratio_load = '0;
        wait_tick(0, 20, n, acks);
        check("last-wins period", 32'(3 + n), 32'd5);
        check("last-wins ack count", 32'(acks), 32'd1);
        check("ack at boundary", 32'(ratio_ack[0]), 32'd1);
        wait_tick(0, 20, n, acks);
        check("new period 7", 32'(n), 32'd7);
        check("no extra ack", 32'(acks), 32'd0);

        // Load exactly on the wrap of ratio 3, then load 0 to halt.
        apply_reset();
        div_ratio[2*W +: W] = 8'd3; ratio_load[2] = 1'b1; chan_en[2] = 1'b1;
        cycle();
        ratio_load = '0;
        wait_tick(2, 20, n, acks);
        cycle();
        cycle();
        div_ratio[2*W +: W] = 8'd6; ratio_load[2] = 1'b1;
        cycle();
        ratio_load = '0;
        check("wrap-load tick,ack", 32'({tick[2], ratio_ack[2]}), 32'd3);
        wait_tick(2, 20, n, acks);
        check("period 6 after wrap-load", 32'(n), 32'd6);
        div_ratio[2*W +: W] = 8'd0; ratio_load[2] = 1'b1;
        cycle();
        ratio_load = '0;
        wait_tick(2, 20, n, acks);
        check("halt period completes", 32'(1 + n), 32'd6);
        check("halt ack", 32'(ratio_ack[2]), 32'd1);
        cnt = 0;
        repeat (10) begin
            cycle();
            if (tick[2] || clk_out[2]) cnt++;
        end
        check("halted outputs", 32'(cnt), 32'd0);

        // Toggle ch1=3 beside pulse ch0=4.
        apply_reset();
        div_ratio[0 +: W] = 8'd4; div_ratio[W +: W] = 8'd3;
        ratio_load = 4'b0011; chan_en = 4'b0011; mode = 4'b0010;
        cycle();
        ratio_load = '0;
        n = 0;
        while (!clk_out[1] && n < 20) begin cycle(); n++; end
        hi = 0;
        while (clk_out[1] && hi < 20) begin hi++; cycle(); end
        lo = 0;
        while (!clk_out[1] && lo < 20) begin lo++; cycle(); end
        check("toggle high run", 32'(hi), 32'd3);
        check("toggle low run", 32'(lo), 32'd3);

        // Enable drop/restore, then reset mid-period.
        apply_reset();
        div_ratio[0 +: W] = 8'd4; ratio_load[0] = 1'b1; chan_en[0] = 1'b1;
        cycle();
        ratio_load = '0;
        wait_tick(0, 20, n, acks);
        cycle();
        chan_en[0] = 1'b0;
        repeat (4) begin
            cycle();
            check("disabled outputs", 32'({clk_out[0], tick[0]}), 32'd0);
        end
        chan_en[0] = 1'b1;
        wait_tick(0, 20, n, acks);
        check("re-enable first tick", 32'(n), 32'd4);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("mid reset outputs", 32'({clk_out, tick, ratio_ack}), 32'd0);
        rst = 1'b0;
        chan_en = '1;
        cnt = 0;
        repeat (10) begin
            cycle();
            if (tick != '0) cnt++;
        end
        check("ratios cleared by reset", 32'(cnt), 32'd0);

`ifdef CLKDIV_SYNC_EN
        apply_reset();
        div_ratio[0 +: W] = 8'd4; ratio_load[0] = 1'b1; chan_en = 4'b0011;
        cycle();
        ratio_load = '0;
        repeat (3) cycle();
        div_ratio[W +: W] = 8'd6; ratio_load[1] = 1'b1;
        cycle();
        ratio_load = '0;
        repeat (7) cycle();
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        repeat (11) cycle();
        cycle();
        check("sync ticks coincide", 32'(tick[1:0]), 32'd3);
`endif

        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            ratio_load = '0;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ratio_load[c] = 1'b1;
                    div_ratio[c*W +: W] = W'($urandom_range(0, 6));
                end
                if ($urandom_range(0, 39) == 0) chan_en[c] = ~chan_en[c];
                if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
            end
`ifdef CLKDIV_SYNC_EN
            sync_in = ($urandom_range(0, 199) == 0);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
